// File: rtl/floo_vc_tx_pkg.sv
// floo_vc_tx_pkg: shared types and helpers for the credit-based VC transmitter
package floo_vc_tx_pkg;

    localparam int unsigned MaxNumVC       = 4;
    localparam int unsigned DefaultVCDepth = 2;

    typedef enum logic [0:0] {IDLE, LOCKED} tx_state_e;

    typedef logic [$clog2(DefaultVCDepth+1)-1:0] credit_cnt_t;

    function automatic logic [1:0] first_set(input logic [MaxNumVC-1:0] mask);
        first_set = 2'd0;
        for (int i = MaxNumVC - 1; i >= 0; i--) begin
            if (mask[i]) first_set = 2'(i);
        end
    endfunction

endpackage

// File: rtl/floo_vc_credit_cnt.sv
// floo_vc_credit_cnt: saturating credit counter for one VC with overflow flag
module floo_vc_credit_cnt #(
    parameter int unsigned Depth = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         inc,
    input  logic                         dec,
    output logic [$clog2(Depth+1)-1:0]   cnt,
    output logic                         ovf
);

    localparam int unsigned W = $clog2(Depth + 1);

    logic at_max;

    assign at_max = cnt == W'(Depth);
    assign ovf    = inc && !dec && at_max;

    // a simultaneous send and credit cancel; a credit at full saturates
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) cnt <= W'(Depth);
        else if (inc && !dec && !at_max) cnt <= cnt + 1'b1;
        else if (dec && !inc) cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/floo_vc_credit_tx.sv
// floo_vc_credit_tx: credit-based VC transmitter with wormhole VC locking
// Optional FLOO_VC_CREDIT_TX_OUT_REG_EN registers data_v_o/data_o/vc_id_o.
module floo_vc_credit_tx
    import floo_vc_tx_pkg::*;
#(
    parameter int unsigned NumVC      = 4,
    parameter int unsigned NumVCWidth = 2,
    parameter int unsigned VCDepth    = 2,
    parameter int unsigned FlitWidth  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [FlitWidth-1:0]  data_i,
    input  logic                  last_i,
    input  logic [NumVCWidth-1:0] pref_vc_i,
    input  logic [NumVC-1:0]      vc_mask_i,
    output logic                  data_v_o,
    output logic [FlitWidth-1:0]  data_o,
    output logic [NumVCWidth-1:0] vc_id_o,
    input  logic                  credit_v_i,
    input  logic [NumVCWidth-1:0] credit_id_i,
    output logic                  credits_full_o,
    output logic                  err_o
);

    localparam int unsigned CntW   = $clog2(VCDepth + 1);
    localparam int unsigned NumIds = 2 ** NumVCWidth;

    logic [CntW-1:0]       cnt [NumVC];
    logic [NumVC-1:0]      has_cred, avail, dec, inc, ovf, full;
    logic [NumIds-1:0]     avail_ext, cred_ext;
    tx_state_e             state_q, state_d;
    logic [NumVCWidth-1:0] lock_q, lock_d, sel;
    logic [NumVCWidth-1:0] vc_q;
    logic [FlitWidth-1:0]  data_q;
    logic                  hs, bad_id, err_q;

    for (genvar v = 0; v < NumVC; v++) begin : g_vc
        floo_vc_credit_cnt #(.Depth(VCDepth)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc[v]),
            .dec   (dec[v]),
            .cnt   (cnt[v]),
            .ovf   (ovf[v])
        );
        assign has_cred[v] = cnt[v] != '0;
        assign full[v]     = cnt[v] == CntW'(VCDepth);
        assign avail[v]    = vc_mask_i[v] && has_cred[v];
        assign dec[v]      = hs && sel == NumVCWidth'(v);
        assign inc[v]      = credit_v_i && credit_id_i == NumVCWidth'(v);
    end

    assign avail_ext      = NumIds'(avail);
    assign cred_ext       = NumIds'(has_cred);
    assign bad_id         = credit_v_i && 32'(credit_id_i) >= NumVC;
    assign credits_full_o = &full;
    assign err_o          = err_q;
    assign hs             = valid_i && ready_o;

    // pick the downstream VC and decide whether a flit may go this cycle
    always_comb begin
        sel     = state_q == LOCKED ? lock_q
                : avail_ext[pref_vc_i] ? pref_vc_i
                : NumVCWidth'(first_set(MaxNumVC'(avail)));
        ready_o = !rst_n && (state_q == LOCKED ? cred_ext[lock_q] : |avail);
    end

    // wormhole lock: the head flit of a multi-flit packet pins the VC
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        if (hs) state_d = last_i ? IDLE : LOCKED;
        if (hs && state_q == IDLE) lock_d = sel;
    end

    // state, lock and sticky error registers
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            lock_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            err_q   <= err_q | bad_id | (|ovf);
        end
    end

    // last sent flit and VC, held while nothing is sent
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            data_q <= '0;
            vc_q   <= '0;
        end else if (hs) begin
            data_q <= data_i;
            vc_q   <= sel;
        end
    end

`ifdef FLOO_VC_CREDIT_TX_OUT_REG_EN
    logic v_q;

    // registered valid: one cycle from handshake to data_v_o
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) v_q <= 1'b0;
        else v_q <= hs;
    end

    assign data_v_o = v_q;
    assign data_o   = data_q;
    assign vc_id_o  = vc_q;
`else
    assign data_v_o = hs;
    assign data_o   = hs ? data_i : data_q;
    assign vc_id_o  = hs ? sel : vc_q;
`endif

endmodule

// File: doc/floo_vc_credit_tx.md
Name: floo_vc_credit_tx

Overview:
Credit-based VC transmitter for the sending side of a floo_vc_router link, as used in a chimney or upstream router output.
- Accepts valid/ready flits from a local source and picks a downstream VC: the preferred VC if it has credit, else the lowest-index allowed VC with credit.
- Tracks per-VC credits and drives data_v_o/vc_id_o to the downstream input port.
- Consumes credit_v_i/credit_id_i returned by the downstream router.
- Locks the chosen VC for a whole wormhole packet.

Parameters:
- NumVC, 4, number of downstream VCs (1..4).
- NumVCWidth, 2, width of the VC id (>= clog2(NumVC), min 1).
- VCDepth, 2, downstream buffer slots per VC; also the credit reset value.
- FlitWidth, 64, flit payload width including header.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- valid_i  in  1  source flit valid
- ready_o  out  1  source flit accepted when valid_i && ready_o
- data_i  in  FlitWidth  source flit
- last_i  in  1  flit is last of packet
- pref_vc_i  in  NumVCWidth  preferred downstream VC
- vc_mask_i  in  NumVC  VCs allowed for this flit's route
- data_v_o  out  1  flit valid to downstream
- data_o  out  FlitWidth  flit to downstream
- vc_id_o  out  NumVCWidth  VC of data_o; integration writes it into hdr.vc_id
- credit_v_i  in  1  credit return valid
- credit_id_i  in  NumVCWidth  VC of returned credit
- credits_full_o  out  1  all counters equal VCDepth (link quiescent)
- err_o  out  1  sticky protocol error

Behaviour:
Reset (rst_n=1, asynchronous):
- All credit counters = VCDepth; state IDLE; lock_vc = 0.
- data_v_o=0, vc_id_o=0, data_o=0, err_o=0, credits_full_o=1.
- ready_o=0 while reset is asserted.

Credit counters:
- One per VC, width clog2(VCDepth+1), unsigned.
- Send on VC v: counter v decrements.
- Credit on VC v: counter v increments.
- Send and credit on the same VC in the same cycle: counter unchanged.
- Credit while counter == VCDepth: counter saturates and err_o is set.
- credit_id_i >= NumVC: credit ignored and err_o is set.
- err_o clears only on reset.

VC selection (combinational):
- avail[v] = vc_mask_i[v] && credit[v] > 0.
- IDLE: sel = pref_vc_i if avail[pref_vc_i], else lowest set bit of avail. ready_o = |avail.
- LOCKED: sel = lock_vc. ready_o = credit[lock_vc] > 0. vc_mask_i and pref_vc_i are ignored.
- Credits returned in cycle t are usable from cycle t+1; there is no same-cycle bypass.
- Zero credit on a VC never yields a send on it.

State machine:
- IDLE -> LOCKED on a handshake with last_i=0; lock_vc <= sel.
- IDLE -> IDLE on a handshake with last_i=1 (single-flit packet).
- LOCKED -> IDLE on a handshake with last_i=1.
- LOCKED holds otherwise.

Output timing (default):
- data_v_o = valid_i && ready_o; data_o = data_i; vc_id_o = sel; zero latency.
- When data_v_o=0, data_o and vc_id_o hold their previous values.
- Downstream never backpressures; credits are the only flow control.

Reset mid-packet: lock is dropped and counters refill. The downstream router must be reset together with this block.

Optional Feature:
Macro: FLOO_VC_CREDIT_TX_OUT_REG_EN.
- Defined: data_v_o, data_o and vc_id_o are registered, giving one cycle latency from handshake to data_v_o. The counter still decrements at the handshake cycle. ready_o stays combinational, so throughput remains one flit per cycle.
- Undefined: combinational path as described under Behaviour.

Decomposition:
- Shared package floo_vc_tx_pkg:
  - tx_state_e {IDLE, LOCKED}
  - function first_set(mask) returning the lowest set index
  - typedef credit_cnt_t sized from VCDepth
- Sub-module floo_vc_credit_cnt: a single saturating up/down counter with overflow flag, instantiated NumVC times.

Test Plan:
1. NumVC=4, VCDepth=2, vc_mask=4'b1111, pref=0: send 8 single-flit packets with no credits returned -> vc_id_o sequence 0,0,1,1,2,2,3,3. Ninth flit: ready_o=0 and data_v_o=0.
2. Credit fallback: credit[2]=0, pref=2, mask=4'b0110 -> vc_id_o=1. Return credit id 2 in cycle t -> a flit with pref=2 at t+1 goes out on vc 2.
3. Wormhole: 4-flit packet, head chooses vc 3. Change pref/mask mid-packet -> all 4 flits on vc 3. After 2 flits, credit[3]=0 -> stall until a credit is returned, then resume on vc 3.
4. Simultaneous: credit[1]=1, send on vc 1 and return credit id 1 in the same cycle -> credit[1] stays 1; credits_full_o stays 0.
5. Error: return credit id 0 while credit[0]=2 -> err_o=1 (sticky), credit[0] stays 2. credit_id_i=3 with NumVC=3 -> err_o=1, no counter change.
6. Reset mid-packet, with and without FLOO_VC_CREDIT_TX_OUT_REG_EN -> all counters = 2, state IDLE, data_v_o=0, credits_full_o=1. With the macro, data_v_o appears exactly one cycle after each handshake.
